// File: rtl/rmt_pkg.sv
// Shared types for the key-offset config scheduler.
// Entry widths, FSM encoding and the buffered request bundle.
package rmt_pkg;

  localparam int KEY_OFF    = 18;
  localparam int AXIL_WIDTH = 32;
  localparam int ADDR_W     = 4;
  localparam int STAGE_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WRITE = 2'd2
  } cfg_state_e;

  typedef struct packed {
    logic [STAGE_W-1:0]    stage;
    logic [ADDR_W-1:0]     addr;
    logic [AXIL_WIDTH-1:0] data;
  } cfg_req_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cfg_req_fifo.sv
// Synchronous request FIFO, first-word fall-through.
// DEPTH must be a power of two; push is taken when full if a pop coincides.
module cfg_req_fifo
  import rmt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  cfg_req_t din,
  input  logic     pop,
  output cfg_req_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  cfg_req_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/key_off_cfg_sched.sv
// Key-offset RAM write scheduler with lookup-conflict deferral.
// KEY_OFF_CFG_SHADOW_EN adds a readable shadow copy of every stage table.
module key_off_cfg_sched
  import rmt_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_STALL  = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [STAGE_W-1:0]           cfg_stage,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic [AXIL_WIDTH-1:0]        cfg_data,
  input  logic [NUM_STAGES-1:0]        lkup_valid,
  input  logic [NUM_STAGES*ADDR_W-1:0] lkup_addr,
  output logic [AXIL_WIDTH-1:0]        key_off_entry_out,
  output logic [ADDR_W-1:0]            key_off_entry_addr,
  output logic [NUM_STAGES-1:0]        key_off_entry_vld,
  output logic                         busy,
`ifdef KEY_OFF_CFG_SHADOW_EN
  input  logic [STAGE_W-1:0]           rd_stage,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [KEY_OFF-1:0]           rd_data,
`endif
  output logic [15:0]                  wr_cnt,
  output logic [15:0]                  stall_cnt,
  output logic [15:0]                  err_cnt
);

  localparam int TW = $clog2(MAX_STALL + 1);

  cfg_state_e                  state_q;
  cfg_state_e                  state_d;
  cfg_req_t                    hold_q;
  cfg_req_t                    fifo_dout;
  cfg_req_t                    fifo_din;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;
  logic                        fifo_push;
  logic [NUM_STAGES-1:0]       lkup_valid_q;
  logic [NUM_STAGES*ADDR_W-1:0] lkup_addr_q;
  logic [TW-1:0]               timer_q;
  logic                        conflict;
  logic                        bad_stage;
  logic                        timeout;
  logic                        stall_inc;
  logic                        err_inc;

  assign cfg_ready = !fifo_full;
  assign fifo_push = cfg_valid && cfg_ready;
  assign fifo_din  = '{stage: cfg_stage, addr: cfg_addr, data: cfg_data};
  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign bad_stage = 32'(hold_q.stage) >= NUM_STAGES;
  assign timeout   = 32'(timer_q) == MAX_STALL;

  cfg_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Hazard window spans this cycle's lookup and the one before it.
  always_comb begin
    conflict = 1'b0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (32'(hold_q.stage) == s) begin
        conflict =
          (lkup_valid[s] &&
           lkup_addr[s*ADDR_W +: ADDR_W] == hold_q.addr) ||
          (lkup_valid_q[s] &&
           lkup_addr_q[s*ADDR_W +: ADDR_W] == hold_q.addr);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    stall_inc = 1'b0;
    err_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bad_stage) begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end else if (conflict && !timeout) begin
          stall_inc = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      lkup_valid_q <= '0;
      lkup_addr_q  <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      lkup_valid_q <= lkup_valid;
      lkup_addr_q  <= lkup_addr;
      if (fifo_pop) hold_q <= fifo_dout;
      if (state_q != ST_CHECK)
        timer_q <= '0;
      else if (stall_inc)
        timer_q <= timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_off_entry_out  <= '0;
      key_off_entry_addr <= '0;
      key_off_entry_vld  <= '0;
      wr_cnt             <= '0;
      stall_cnt          <= '0;
      err_cnt            <= '0;
    end else begin
      key_off_entry_vld <= '0;
      if (state_q == ST_WRITE) begin
        key_off_entry_vld  <= NUM_STAGES'(1) << hold_q.stage;
        key_off_entry_out  <= hold_q.data;
        key_off_entry_addr <= hold_q.addr;
        wr_cnt             <= sat_inc(wr_cnt);
      end
      if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
      if (err_inc)   err_cnt   <= sat_inc(err_cnt);
    end
  end

`ifdef KEY_OFF_CFG_SHADOW_EN
  logic [KEY_OFF-1:0] shadow_q [NUM_STAGES][2**ADDR_W];

  // Read samples before the same-edge write lands, returning the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_STAGES; s++)
        for (int a = 0; a < 2**ADDR_W; a++)
          shadow_q[s][a] <= '0;
      rd_data <= '0;
    end else begin
      if (state_q == ST_WRITE)
        shadow_q[hold_q.stage][hold_q.addr] <= hold_q.data[KEY_OFF-1:0];
      rd_data <= (32'(rd_stage) < NUM_STAGES) ?
                 shadow_q[rd_stage][rd_addr] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_key_off_cfg_sched.sv
// Directed bench for key_off_cfg_sched.
// Define KEY_OFF_CFG_SHADOW_EN to also exercise the shadow read port.
module tb_key_off_cfg_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_stage;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [4:0]  lkup_valid;
  logic [19:0] lkup_addr;
  logic [31:0] entry_out;
  logic [3:0]  entry_addr;
  logic [4:0]  entry_vld;
  logic        busy;
  logic [15:0] wr_cnt;
  logic [15:0] stall_cnt;
  logic [15:0] err_cnt;
`ifdef KEY_OFF_CFG_SHADOW_EN
  logic [2:0]  rd_stage;
  logic [3:0]  rd_addr;
  logic [17:0] rd_data;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  vld;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t log_q[$];
  wr_t exp_q[$];

  key_off_cfg_sched dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .cfg_stage          (cfg_stage),
    .cfg_addr           (cfg_addr),
    .cfg_data           (cfg_data),
    .lkup_valid         (lkup_valid),
    .lkup_addr          (lkup_addr),
    .key_off_entry_out  (entry_out),
    .key_off_entry_addr (entry_addr),
    .key_off_entry_vld  (entry_vld),
    .busy               (busy),
`ifdef KEY_OFF_CFG_SHADOW_EN
    .rd_stage           (rd_stage),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data),
`endif
    .wr_cnt             (wr_cnt),
    .stall_cnt          (stall_cnt),
    .err_cnt            (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (entry_vld != '0)
      log_q.push_back('{entry_vld, entry_addr, entry_out});
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(
    input logic [2:0]  st,
    input logic [3:0]  a,
    input logic [31:0] d
  );
    int n = 0;
    cfg_valid = 1'b1;
    cfg_stage = st;
    cfg_addr  = a;
    cfg_data  = d;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", 32'(n < 50), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic expect_wr(
    input logic [4:0]  v,
    input logic [3:0]  a,
    input logic [31:0] d
  );
    exp_q.push_back('{v, a, d});
  endtask

  task automatic compare_log(input string tag);
    chk({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({tag, "_vld"},  32'(log_q[i].vld),  32'(exp_q[i].vld));
      chk({tag, "_addr"}, 32'(log_q[i].addr), 32'(exp_q[i].addr));
      chk({tag, "_data"}, log_q[i].data,      exp_q[i].data);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_vld(output int n, input int limit);
    n = 0;
    while (entry_vld == '0 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int lat;
    int pulses;
    logic [4:0] vseen;
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_stage  = '0;
    cfg_addr   = '0;
    cfg_data   = '0;
    lkup_valid = '0;
    lkup_addr  = '0;
`ifdef KEY_OFF_CFG_SHADOW_EN
    rd_stage   = '0;
    rd_addr    = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_vld",   32'(entry_vld),  32'd0);
    chk("rst_out",   entry_out,       32'd0);
    chk("rst_addr",  32'(entry_addr), 32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_ready", 32'(cfg_ready),  32'd1);
    chk("rst_cnts",  {wr_cnt, stall_cnt | err_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single write, latency and pulse width
    push(3'd2, 4'd5, 32'h2AAAA);
    lat    = -1;
    pulses = 0;
    vseen  = '0;
    for (int k = 0; k < 8; k++) begin
      if (entry_vld != '0) begin
        pulses++;
        if (lat < 0) begin
          lat   = k;
          vseen = entry_vld;
        end
      end
      @(negedge clk);
    end
    chk("t1_lat",    32'(lat),        32'd3);
    chk("t1_vld",    32'(vseen),      32'h04);
    chk("t1_pulses", 32'(pulses),     32'd1);
    chk("t1_hold",   entry_out,       32'h2AAAA);
    chk("t1_addr",   32'(entry_addr), 32'd5);
    chk("t1_wrcnt",  32'(wr_cnt),     32'd1);
    expect_wr(5'b00100, 4'd5, 32'h2AAAA);
    compare_log("t1");

    // six-cycle lookup conflict
    push(3'd0, 4'd3, 32'h01234);
    @(negedge clk);
    lkup_valid = 5'b00001;
    lkup_addr  = 20'h00003;
    repeat (6) @(negedge clk);
    lkup_valid = '0;
    wait_vld(n, 20);
    chk("t2_lat",   32'(n),         32'd3);
    chk("t2_vld",   32'(entry_vld), 32'h01);
    chk("t2_stall", 32'(stall_cnt), 32'd7);
    repeat (3) @(negedge clk);
    expect_wr(5'b00001, 4'd3, 32'h01234);
    compare_log("t2");

    // permanent conflict forces the write
    push(3'd1, 4'd9, 32'h3F00F);
    lkup_valid = 5'b00010;
    lkup_addr  = 20'h00090;
    wait_vld(n, 40);
    chk("t3_lat",   32'(n),         32'd18);
    chk("t3_vld",   32'(entry_vld), 32'h02);
    chk("t3_stall", 32'(stall_cnt), 32'd22);
    lkup_valid = '0;
    repeat (3) @(negedge clk);
    expect_wr(5'b00010, 4'd9, 32'h3F00F);
    compare_log("t3");

    // fill the FIFO behind a stalled head
    lkup_valid = 5'b00001;
    lkup_addr  = 20'h00001;
    push(3'd0, 4'd1, 32'h00A01);
    push(3'd1, 4'd2, 32'h00B02);
    push(3'd2, 4'd3, 32'h00C03);
    push(3'd3, 4'd4, 32'h00D04);
    push(3'd4, 4'd5, 32'h00E05);
    chk("t4_full",  32'(cfg_ready), 32'd0);
    chk("t4_busy",  32'(busy),      32'd1);
    chk("t4_nowr",  32'(wr_cnt),    32'd3);
    lkup_valid = '0;
    push(3'd0, 4'd6, 32'h00F06);
    repeat (30) @(negedge clk);
    expect_wr(5'b00001, 4'd1, 32'h00A01);
    expect_wr(5'b00010, 4'd2, 32'h00B02);
    expect_wr(5'b00100, 4'd3, 32'h00C03);
    expect_wr(5'b01000, 4'd4, 32'h00D04);
    expect_wr(5'b10000, 4'd5, 32'h00E05);
    expect_wr(5'b00001, 4'd6, 32'h00F06);
    compare_log("t4");
    chk("t4_idle", 32'(busy), 32'd0);

    // out-of-range stage dropped
    push(3'd6, 4'd2, 32'h11111);
    push(3'd3, 4'd8, 32'h22222);
    repeat (12) @(negedge clk);
    chk("t5_err",   32'(err_cnt), 32'd1);
    chk("t5_wrcnt", 32'(wr_cnt),  32'd10);
    expect_wr(5'b01000, 4'd8, 32'h22222);
    compare_log("t5");

`ifdef KEY_OFF_CFG_SHADOW_EN
    push(3'd1, 4'd7, 32'h00155);
    repeat (8) @(negedge clk);
    rd_stage = 3'd1;
    rd_addr  = 4'd7;
    @(negedge clk);
    chk("sh_read", 32'(rd_data), 32'h155);
    rd_stage = 3'd6;
    @(negedge clk);
    chk("sh_oob", 32'(rd_data), 32'h0);
    rd_stage = 3'd2;
    rd_addr  = 4'd5;
    @(negedge clk);
    chk("sh_t1", 32'(rd_data), 32'h2AAAA);
    expect_wr(5'b00010, 4'd7, 32'h00155);
    compare_log("sh");
`endif

    // reset while holding a request in CHECK
    lkup_valid = 5'b00100;
    lkup_addr  = 20'h00000;
    push(3'd2, 4'd0, 32'h33333);
    push(3'd1, 4'd1, 32'h44444);
    push(3'd3, 4'd3, 32'h55555);
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst",  32'(busy),      32'd0);
    chk("t6_ready_rst", 32'(cfg_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    lkup_valid = '0;
    repeat (10) @(negedge clk);
    compare_log("t6");
    chk("t6_busy",  32'(busy),      32'd0);
    chk("t6_ready", 32'(cfg_ready), 32'd1);
    chk("t6_cnts",  {wr_cnt, stall_cnt | err_cnt}, 32'd0);
    chk("t6_out",   entry_out,      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
